// File: rtl/vbsme_pkg.sv
// Shared definitions for the VBSME minimum-SAD search blocks: width defaults,
// the SAD all-ones sentinel and the scheduler FSM state encoding.
// Optional feature macro used by the scheduler: SAD_MIN_THRESH_EN.
package vbsme_pkg;

  localparam int SAD_W_DEF = 32;
  localparam int IDX_W_DEF = 16;

  // Sentinel for "no candidate yet" and for masked lanes.
  localparam logic [SAD_W_DEF-1:0] SAD_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sad_min_scheduler_if.sv
// SAD-group stream from the SAD array into the min-SAD scheduler.
// The master (SAD array) drives the group and valid; the slave answers ready.
interface sad_min_scheduler_if #(
  parameter int LANES = 16,
  parameter int SAD_W = 32
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*SAD_W-1:0] in_sad;
  logic [LANES-1:0]       in_mask;

  modport master (
    output in_valid,
    output in_sad,
    output in_mask,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sad,
    input  in_mask,
    output in_ready
  );

endinterface

// File: rtl/sad_min_tree.sv
// Combinational LANES-input min/argmin tree. Masked lanes never win; on equal
// SADs the lower lane wins. any_valid is low when every lane is masked.
module sad_min_tree #(
  parameter  int LANES = 16,
  parameter  int SAD_W = 32,
  localparam int LG    = $clog2(LANES)
) (
  input  logic [LANES*SAD_W-1:0] sad,
  input  logic [LANES-1:0]       mask,
  output logic [SAD_W-1:0]       min_sad,
  output logic [LG-1:0]          min_lane,
  output logic                   any_valid
);

  // Level 0 holds the lanes; each further level halves the candidate count.
  for (genvar l = 0; l <= LG; l++) begin : lvl_g
    localparam int N = LANES >> l;

    logic [SAD_W-1:0] sad_a  [N];
    logic [LG-1:0]    lane_a [N];
    logic             vld_a  [N];

    if (l == 0) begin : leaf_g
      for (genvar k = 0; k < N; k++) begin : lane_g
        // Masked lanes carry the all-ones sentinel and a cleared valid.
        assign sad_a[k]  = mask[k] ? sad[k*SAD_W +: SAD_W] : '1;
        assign lane_a[k] = LG'(k);
        assign vld_a[k]  = mask[k];
      end
    end else begin : cmp_g
      for (genvar k = 0; k < N; k++) begin : node_g
        logic take_hi;
        // The upper (higher-lane) child wins only on a strictly smaller valid SAD.
        assign take_hi = lvl_g[l-1].vld_a[2*k+1] &&
                         (!lvl_g[l-1].vld_a[2*k] ||
                          (lvl_g[l-1].sad_a[2*k+1] < lvl_g[l-1].sad_a[2*k]));
        assign sad_a[k]  = take_hi ? lvl_g[l-1].sad_a[2*k+1]  : lvl_g[l-1].sad_a[2*k];
        assign lane_a[k] = take_hi ? lvl_g[l-1].lane_a[2*k+1] : lvl_g[l-1].lane_a[2*k];
        assign vld_a[k]  = lvl_g[l-1].vld_a[2*k] | lvl_g[l-1].vld_a[2*k+1];
      end
    end
  end

  assign min_sad   = lvl_g[LG].sad_a[0];
  assign min_lane  = lvl_g[LG].lane_a[0];
  assign any_valid = lvl_g[LG].vld_a[0];

endmodule

// File: rtl/sad_min_scheduler.sv
// Minimum-SAD search sequencer: accepts num_groups SAD groups, reduces each to
// a winner (stage 1), folds winners into a running best (stage 2) and pulses
// done with the final best SAD / candidate index.
// Optional feature macro: SAD_MIN_THRESH_EN (early termination on thresh).
module sad_min_scheduler
  import vbsme_pkg::*;
#(
  parameter int LANES = 16,
  parameter int SAD_W = SAD_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int GRP_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GRP_W-1:0]      num_groups,
  sad_min_scheduler_if.slave    in_if,
  output logic                  busy,
  output logic                  done,
  output logic [SAD_W-1:0]      best_sad,
  output logic [IDX_W-1:0]      best_idx
`ifdef SAD_MIN_THRESH_EN
  ,
  input  logic [SAD_W-1:0]      thresh,
  output logic                  early_term
`endif
);

  localparam int LG = $clog2(LANES);

  sched_state_t     state_q, state_d;
  logic [GRP_W-1:0] num_groups_q, num_groups_d;
  logic [GRP_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [SAD_W-1:0] s1_sad_q, s1_sad_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SAD_MIN_THRESH_EN
  logic             et_q, et_d;
  logic             early_term_q, early_term_d;
`endif

  logic [SAD_W-1:0] t_sad;
  logic [LG-1:0]    t_lane;
  logic             t_any;
  logic [IDX_W-1:0] t_idx;
  logic             accept;
  logic             upd;

  sad_min_tree #(
    .LANES (LANES),
    .SAD_W (SAD_W)
  ) u_tree (
    .sad       (in_if.in_sad),
    .mask      (in_if.in_mask),
    .min_sad   (t_sad),
    .min_lane  (t_lane),
    .any_valid (t_any)
  );

  // Candidate index = group*LANES + lane; LANES is a power of two, so this is
  // a concatenation, truncated (wrapping) to IDX_W.
  assign t_idx  = IDX_W'({grp_cnt_q, t_lane});
  assign accept = in_if.in_valid && in_ready_q;
  // Strict compare: equal SADs keep the earlier group's candidate.
  assign upd    = s1_valid_q && (s1_sad_q < best_sad_q);

  // Next-state logic for the FSM, both pipeline stages and all outputs.
  always_comb begin
    // NOTE: every _d defaults to its _q so no branch can leave a latch behind.
    state_d      = state_q;
    num_groups_d = num_groups_q;
    grp_cnt_d    = grp_cnt_q;
    s1_sad_d     = accept ? t_sad : s1_sad_q;
    s1_idx_d     = accept ? t_idx : s1_idx_q;
    // A fully masked group is consumed but never enters stage 2.
    s1_valid_d   = accept && t_any;
    best_sad_d   = upd ? s1_sad_q : best_sad_q;
    best_idx_d   = upd ? s1_idx_q : best_idx_q;
`ifdef SAD_MIN_THRESH_EN
    et_d         = et_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          num_groups_d = num_groups;
          grp_cnt_d    = '0;
          best_sad_d   = '1;
          best_idx_d   = '0;
          state_d      = (num_groups == '0) ? DONE : RUN;
`ifdef SAD_MIN_THRESH_EN
          et_d         = 1'b0;
`endif
        end
      end
      RUN: begin
        if (accept) begin
          grp_cnt_d = grp_cnt_q + GRP_W'(1);
          if (grp_cnt_q == num_groups_q - GRP_W'(1)) state_d = DRAIN;
        end
`ifdef SAD_MIN_THRESH_EN
        // A real improvement at or below thresh stops intake; stage 1 still retires.
        if (upd && (s1_sad_q <= thresh)) begin
          state_d = DRAIN;
          et_d    = 1'b1;
        end
`endif
      end
      // in_ready is already low here, so stage 1 holds at most one beat and
      // stage 2 retires it on this edge.
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d       = (state_q == DONE);
    busy_d       = (state_d != IDLE) || done_d;
    in_ready_d   = (state_d == RUN);
`ifdef SAD_MIN_THRESH_EN
    early_term_d = done_d && et_q;
`endif
  end

  // State and output registers with synchronous reset; in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      num_groups_q <= '0;
      grp_cnt_q    <= '0;
      s1_sad_q     <= '0;
      s1_idx_q     <= '0;
      s1_valid_q   <= 1'b0;
      best_sad_q   <= '1;
      best_idx_q   <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SAD_MIN_THRESH_EN
      et_q         <= 1'b0;
      early_term_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      num_groups_q <= num_groups_d;
      grp_cnt_q    <= grp_cnt_d;
      s1_sad_q     <= s1_sad_d;
      s1_idx_q     <= s1_idx_d;
      s1_valid_q   <= s1_valid_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SAD_MIN_THRESH_EN
      et_q         <= et_d;
      early_term_q <= early_term_d;
`endif
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign best_sad       = best_sad_q;
  assign best_idx       = best_idx_q;
`ifdef SAD_MIN_THRESH_EN
  assign early_term     = early_term_q;
`endif

endmodule

// File: tb/tb_sad_min_scheduler.sv
// Self-checking bench for sad_min_scheduler (LANES=16, SAD_W=32, IDX_W=16).
// Expected results come from a plain scan-all-candidates reference model.
module tb_sad_min_scheduler;
  import vbsme_pkg::*;

  localparam int LANES = 16;
  localparam int SAD_W = 32;
  localparam int IDX_W = 16;
  localparam int GRP_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [GRP_W-1:0] num_groups;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
`ifdef SAD_MIN_THRESH_EN
  logic [SAD_W-1:0] thresh;
  logic             early_term;
`endif

  sad_min_scheduler_if #(.LANES(LANES), .SAD_W(SAD_W)) bus ();

  sad_min_scheduler #(
    .LANES (LANES),
    .SAD_W (SAD_W),
    .IDX_W (IDX_W),
    .GRP_W (GRP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_groups (num_groups),
    .in_if      (bus),
    .busy       (busy),
    .done       (done),
    .best_sad   (best_sad),
    .best_idx   (best_idx)
`ifdef SAD_MIN_THRESH_EN
    ,
    .thresh     (thresh),
    .early_term (early_term)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus store: up to 16 groups of 16 lanes.
  logic [SAD_W-1:0] gs [0:15][0:15];
  logic [LANES-1:0] gm [0:15];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan every enabled candidate in arrival order, keep the first
  // strict minimum; all-ones/0 when nothing beats the sentinel.
  function automatic void model(input int n, output logic [SAD_W-1:0] es,
                                output logic [IDX_W-1:0] ei);
    es = '1;
    ei = '0;
    for (int g = 0; g < n; g++)
      for (int k = 0; k < LANES; k++)
        if (gm[g][k] && gs[g][k] < es) begin
          es = gs[g][k];
          ei = IDX_W'(g * LANES + k);
        end
  endfunction

  task automatic drive_group(input int g);
    for (int k = 0; k < LANES; k++) bus.in_sad[k*SAD_W +: SAD_W] = gs[g][k];
    bus.in_mask = gm[g];
  endtask

  task automatic fill(input int n, input int lo, input int hi);
    for (int g = 0; g < n; g++) begin
      gm[g] = '1;
      for (int k = 0; k < LANES; k++) gs[g][k] = SAD_W'($urandom_range(hi, lo));
    end
  endtask

  // gap_mode: 0 = valid every cycle, 1 = every other cycle, 2 = random.
  task automatic run_search(input string tag, input int n, input int gap_mode,
                            input bit poke_start, input bit exp_early);
    logic [SAD_W-1:0] es;
    logic [IDX_W-1:0] ei;
    int g, cyc, lat;
    bit v;
    model(n, es, ei);
    start = 1'b1;
    num_groups = GRP_W'(n);
    step();
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    lat = 1;
    if (n > 0) begin
      g = 0;
      cyc = 0;
      while (g < n && cyc < 400 && bus.in_ready === 1'b1) begin
        v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? cyc[0] == 1'b0 : 1'($urandom_range(1, 0));
        bus.in_valid = v;
        drive_group(g);
        if (poke_start && cyc == 2) begin
          start = 1'b1;
          num_groups = GRP_W'(1);
        end
        step();
        start = 1'b0;
        num_groups = GRP_W'(n);
        if (v) g++;
        cyc++;
      end
      bus.in_valid = 1'b0;
      if (!exp_early) begin
        check({tag, " beats consumed"}, 64'(g), 64'(n));
        check({tag, " ready low after last"}, 64'(bus.in_ready), 64'd0);
      end else begin
        check({tag, " beats within bound"}, 64'(g >= 2 && g <= 3), 64'd1);
      end
    end
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    if (!exp_early) check({tag, " done latency"}, 64'(lat), (n == 0) ? 64'd2 : 64'd3);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " best_sad"}, 64'(best_sad), 64'(es));
    check({tag, " best_idx"}, 64'(best_idx), 64'(ei));
    check({tag, " busy in done"}, 64'(busy), 64'd1);
`ifdef SAD_MIN_THRESH_EN
    check({tag, " early_term"}, 64'(early_term), 64'(exp_early));
`endif
    step();
    check({tag, " done pulse ends"}, 64'(done), 64'd0);
    check({tag, " idle after done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_groups = '0;
    bus.in_valid = 1'b0;
    bus.in_sad = '0;
    bus.in_mask = '0;
`ifdef SAD_MIN_THRESH_EN
    thresh = '0;
`endif
    repeat (3) step();
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset best_sad", 64'(best_sad), 64'(SAD_ALL_ONES));
    check("reset best_idx", 64'(best_idx), 64'd0);
    rst = 1'b0;
    step();

    // Single group: 100..115 with lane 7 = 5.
    gm[0] = '1;
    for (int k = 0; k < LANES; k++) gs[0][k] = SAD_W'(100 + k);
    gs[0][7] = 5;
    run_search("single", 1, 0, 1'b0, 1'b0);

    // Four groups, minimum 20 at group 2 lane 3, valid every other cycle.
    fill(4, 21, 1000);
    gs[2][3] = 20;
    run_search("gapped", 4, 1, 1'b0, 1'b0);

    // Ties: lower lane wins, a later equal value does not replace.
    fill(2, 50, 90);
    gs[0][2] = 8;
    gs[0][9] = 8;
    gs[1][0] = 8;
    run_search("ties", 2, 0, 1'b0, 1'b0);

    // Masked lane with SAD 0 must not win.
    fill(1, 100, 200);
    gs[0][0] = 0;
    gs[0][4] = 50;
    gm[0][0] = 1'b0;
    run_search("mask lane", 1, 0, 1'b0, 1'b0);

    // Fully masked group.
    fill(1, 0, 30);
    gm[0] = '0;
    run_search("mask all", 1, 0, 1'b0, 1'b0);

    // Empty search.
    run_search("zero groups", 0, 0, 1'b0, 1'b0);

    // Reset after 2 of 5 beats, then a normal search.
    fill(5, 1, 500);
    start = 1'b1;
    num_groups = GRP_W'(5);
    step();
    start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      bus.in_valid = 1'b1;
      drive_group(g);
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("midrst in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst best_sad", 64'(best_sad), 64'(SAD_ALL_ONES));
    check("midrst best_idx", 64'(best_idx), 64'd0);
    rst = 1'b0;
    step();
    run_search("after reset", 5, 0, 1'b0, 1'b0);

    // start pulsed mid-run is ignored; the minimum sits in the last group.
    fill(4, 30, 400);
    gs[3][11] = 2;
    run_search("start in run", 4, 0, 1'b1, 1'b0);

    // Randomized searches with dense ties, random masks and random gaps.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(6, 1);
      fill(n, 1, 40);
      for (int g = 0; g < n; g++) gm[g] = LANES'($urandom);
      if (r == 3) gm[0] = '0;
      run_search("random", n, 2, 1'b0, 1'b0);
    end

`ifdef SAD_MIN_THRESH_EN
    // Early termination: SAD 9 in group 1 with thresh 10.
    fill(8, 100, 300);
    gs[1][5] = 9;
    thresh = 10;
    run_search("early term", 8, 0, 1'b0, 1'b1);
    thresh = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_min_scheduler.md
# sad_min_scheduler

Sequencing controller for the VBSME minimum-SAD search. It accepts a stream of SAD groups from the SAD array, `LANES` candidates per beat, under a valid/ready handshake. Each group is reduced to one winner through a combinational pairwise-compare tree, and a running best SAD and candidate index are kept across the whole search window. It pulses `done` with the final motion-vector candidate, and sits between the SAD array and the motion-vector output logic.

## Interface
Parameters:
- `LANES`, 16: SADs per input beat; power of two, ≥2.
- `SAD_W`, 32: SAD width, unsigned.
- `IDX_W`, 16: candidate index width.
- `GRP_W`, 12: width of the group counter.

Ports:
- `clk` input, 1 bit: the single clock; all logic on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begins a search when idle; ignored while busy.
- `num_groups` input, GRP_W bits: beats in this search; latched on `start`.
- `in_valid` input, 1 bit: SAD group valid.
- `in_ready` output, 1 bit: block accepts a group this cycle.
- `in_sad` input, LANES*SAD_W bits: lane k occupies bits [k*SAD_W +: SAD_W].
- `in_mask` input, LANES bits: lane enable; masked lanes never win.
- `thresh` input, SAD_W bits: early-termination threshold (only with `SAD_MIN_THRESH_EN`).
- `busy` output, 1 bit: search in progress.
- `done` output, 1 bit: one-cycle pulse when the result is final.
- `best_sad` output, SAD_W bits: minimum SAD; held until the next `start`.
- `best_idx` output, IDX_W bits: index of the winning candidate, equal to group*LANES + lane, truncated to IDX_W.
- `early_term` output, 1 bit: valid with `done` (only with `SAD_MIN_THRESH_EN`).

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. `num_groups` is latched, `best_sad` is set to all-ones, `best_idx` to 0, and the group counter to 0.
  - If `start` arrives with `num_groups`=0, the FSM goes IDLE → DONE directly and the result is all-ones/0.
- RUN: `in_ready`=1. A beat is accepted when `in_valid && in_ready`. On the last accepted beat (counter = `num_groups`-1), the FSM goes to DRAIN.
- DRAIN: `in_ready`=0. The FSM waits until the pipeline is empty, then goes to DONE.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- Reduction tree:
  - log2(LANES) levels of 2-input compares.
  - Masked lanes are treated as SAD all-ones and are never selected.
  - On a tie, the lower lane wins.
- Running update: replace `best_sad`/`best_idx` only when group min < `best_sad` (strict compare). A tie therefore keeps the earlier group.
- A fully masked group counts toward `num_groups` but never updates the result.
- Arithmetic: comparisons are unsigned on SAD_W bits. The index arithmetic wraps modulo 2^IDX_W.

## Timing
- Reset values:
  - `in_ready`=0, `busy`=0, `done`=0, `early_term`=0.
  - `best_sad`=all-ones, `best_idx`=0.
  - FSM in IDLE, counters 0.
- Pipeline:
  - Stage 1 registers the tree winner (SAD, index, valid).
  - Stage 2 compares it against the running best and updates.
- Latency: `done` asserts 3 cycles after the last beat is accepted (stage1, stage2, DONE). `best_sad`/`best_idx` are final in the cycle `done` is high.
- `busy` is high from the cycle after `start` through the `done` cycle.
- `in_ready` is independent of `in_valid` in the same cycle. When `in_valid` is low, the FSM stalls and no bubble corrupts the count.
- A `start` during RUN, DRAIN or DONE is ignored.
- `rst` mid-search returns every register to its reset value on the next edge. In-flight groups are discarded.

## Configuration
- `SAD_MIN_THRESH_EN` defined:
  - When stage 2 updates `best_sad` to a value ≤ `thresh`, the FSM goes RUN → DRAIN immediately.
  - Beats already in stage 1 still complete. No further beats are accepted.
  - `early_term`=1 in the `done` cycle.
  - The update still requires strict less-than. An all-ones initial best never triggers termination unless a real update occurs.
- `SAD_MIN_THRESH_EN` undefined: the `thresh` and `early_term` ports are absent and every search consumes exactly `num_groups` beats.

## Structure
- Shared package `vbsme_pkg`:
  - SAD_W and IDX_W defaults.
  - SAD all-ones constant.
  - FSM state enum.
- Sub-module `sad_min_tree`: a combinational, parameterized LANES-input min/argmin tree that takes the mask and outputs (min SAD, lane, any_valid). The scheduler instantiates one.

## Test plan
- Single group, LANES=16, `num_groups`=1. SADs 100..115 with lane 7 = 5, all unmasked. Expect `done` 3 cycles after accept, `best_sad`=5, `best_idx`=7.
- 4 groups, with the minimum 20 in group 2, lane 3, and `in_valid` gapped every other cycle. Expect `best_idx`=35, and `done` 3 cycles after the 4th accept.
- Ties:
  - Lanes 2 and 9 both = 8 in group 0: `best_idx`=2.
  - A later group's lane 0 = 8 does not replace it.
- Masking:
  - Lane 0 = 0 but masked, lane 4 = 50: `best_sad`=50, `best_idx`=4.
  - A fully masked single group: result is all-ones/0.
- `num_groups`=0: `done` 2 cycles after `start`, with `best_sad`=all-ones.
- Reset and start handling:
  - Assert `rst` during RUN after 2 of 5 beats: outputs return to reset values on the next edge, and a new search behaves normally.
  - `start` pulsed in RUN is ignored.
- With `SAD_MIN_THRESH_EN`, `thresh`=10, `num_groups`=8:
  - Group 1 contains SAD 9.
  - Expect at most one further beat accepted, `early_term`=1, `best_sad`=9.
